// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU definitions for the interlock unit: register address width,
// scoreboard entry layout and the bubble value shifted in on stalls.
package hazard_scoreboard_pkg;

    localparam int REG_ADDR_W = 2;
    localparam int SB_DEPTH   = 3;   // S0 = ID/EX, S1 = EX/MEM, S2 = MEM/WB

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      v;
        reg_addr_t rd;
        logic      regwrite;
        logic      memread;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    function automatic sb_entry_t make_entry(input reg_addr_t rd,
                                             input logic      regwrite,
                                             input logic      memread);
        sb_entry_t e;
        e.v        = 1'b1;
        e.rd       = rd;
        e.regwrite = regwrite;
        e.memread  = memread;
        return e;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Combinational comparator: does a scoreboard entry write register r,
// optionally counting only loads.
module hazard_scoreboard_sb_match
    import hazard_scoreboard_pkg::*;
(
    input  sb_entry_t entry,
    input  reg_addr_t r,
    input  logic      load_only,
    output logic      hit
);

    always_comb begin
        // NOTE: always_comb assigns its output on every path so no latch is inferred.
        hit = 1'b0;
        if (entry.v && entry.regwrite && (entry.rd == r))
            hit = !load_only || entry.memread;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Interlock unit: tracks in-flight destinations and stalls the front end on
// load-use and unforwardable branch-source hazards.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [1:0]       id_rs,
    input  logic [1:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [1:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_branch,
    input  logic             ex_flush,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_count
);

    sb_entry_t sb [SB_DEPTH];

    logic s0_load_rs;
    logic s0_load_rt;
    logic s0_write_rs;
    logic s1_load_rs;
    logic load_use;
    logic branch_hazard;

    hazard_scoreboard_sb_match u_s0_load_rs (
        .entry     (sb[0]),
        .r         (id_rs),
        .load_only (1'b1),
        .hit       (s0_load_rs)
    );

    hazard_scoreboard_sb_match u_s0_load_rt (
        .entry     (sb[0]),
        .r         (id_rt),
        .load_only (1'b1),
        .hit       (s0_load_rt)
    );

    // Branches compare in ID, so even an ALU result one stage ahead is too late.
    hazard_scoreboard_sb_match u_s0_write_rs (
        .entry     (sb[0]),
        .r         (id_rs),
        .load_only (1'b0),
        .hit       (s0_write_rs)
    );

    hazard_scoreboard_sb_match u_s1_load_rs (
        .entry     (sb[1]),
        .r         (id_rs),
        .load_only (1'b1),
        .hit       (s1_load_rs)
    );

    assign load_use      = id_valid && ((id_uses_rs && s0_load_rs) ||
                                        (id_uses_rt && s0_load_rt));
    assign branch_hazard = id_valid && id_branch && (s0_write_rs || s1_load_rs);

    // A flush kills the consumer, so it never needs to wait.
    assign stall        = (load_use || branch_hazard) && !ex_flush;
    assign pc_write     = !stall;
    assign if_id_write  = !stall;
    assign id_ex_bubble = stall || ex_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every entry is reset because stale valid bits would raise false hazards.
            for (int k = 0; k < SB_DEPTH; k++)
                sb[k] <= SB_BUBBLE;
        end else begin
            // NOTE: non-blocking assignments let the shift read the old contents of each stage.
            for (int k = SB_DEPTH-1; k > 0; k--)
                sb[k] <= sb[k-1];
            if (id_ex_bubble || !id_valid)
                sb[0] <= SB_BUBBLE;
            else
                sb[0] <= make_entry(id_rd, id_regwrite, id_memread);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule
